// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_t;

   localparam int DEF_N = 4;
   localparam int DEF_W = 8;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: zeroes one entry per cycle from 0 up to DEPTH-1,
// then signals completion for one cycle before returning to idle.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_req,
   output logic         clr_busy,
   output logic         clr_done,
   output logic         clr_we,
   output logic [N-1:0] clr_addr
);

   clr_state_t   state_q;
   logic [N-1:0] clr_ptr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         clr_ptr  <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               clr_done <= 1'b0;
               if (clr_req) begin
                  state_q  <= CLEAR;
                  clr_ptr  <= '0;
                  clr_busy <= 1'b1;
               end
            end
            CLEAR: begin
               // the pointer parks on the last entry instead of wrapping
               if (clr_ptr == '1) begin
                  state_q  <= DONE;
                  clr_done <= 1'b1;
               end else begin
                  clr_ptr <= clr_ptr + 1'b1;
               end
            end
            DONE: begin
               state_q  <= IDLE;
               clr_busy <= 1'b0;
               clr_done <= 1'b0;
            end
            default: begin
               state_q  <= IDLE;
               clr_busy <= 1'b0;
               clr_done <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we   = (state_q == CLEAR);
   assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NWR write ports (higher index wins), NRD read ports,
// combinational-with-bypass or registered write-first reads, built-in bulk clear.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int W        = DEF_W,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int RD_REG   = 0,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NWR-1:0]   we,
   input  logic [NWR*N-1:0] waddr,
   input  logic [NWR*W-1:0] wdata,
   input  logic [NRD*N-1:0] raddr,
   output logic [NRD*W-1:0] rdata,
   output logic             wr_conflict,
   output logic             wr_drop,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic             clr_done
);

   localparam int DEPTH = 1 << N;

   logic [W-1:0]            mem [DEPTH];
   logic                    clr_we;
   logic [N-1:0]            clr_addr;
   logic [NWR-1:0]          we_ok;
   logic [NWR-1:0]          we_eff;
   logic                    conflict;
   logic [NRD-1:0][W-1:0]   rd_comb;
   logic [NRD-1:0][W-1:0]   rd_out;

   regfile_clear_fsm #(.N(N)) u_clear (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // writes to a hard-wired entry 0 vanish entirely: no drop, no conflict
   always_comb begin
      we_ok  = '0;
      we_eff = '0;
      for (int i = 0; i < NWR; i++) begin
         we_ok[i]  = we[i] && !(ZERO_REG != 0 && waddr[i*N +: N] == '0);
         we_eff[i] = we_ok[i] && !clr_busy;
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < NWR; i++)
         for (int k = i + 1; k < NWR; k++)
            if (we_eff[i] && we_eff[k] && waddr[i*N +: N] == waddr[k*N +: N])
               conflict = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem <= '{default: '0};
      end else if (clr_we) begin
         mem[clr_addr] <= '0;
      end else begin
         for (int i = 0; i < NWR; i++)
            if (we_eff[i])
               mem[waddr[i*N +: N]] <= wdata[i*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_conflict <= 1'b0;
         wr_drop     <= 1'b0;
      end else begin
         wr_conflict <= conflict;
         wr_drop     <= clr_busy && (|we_ok);
      end
   end

   // we_eff is already gated by clr_busy, so the bypass is off during a clear
   always_comb begin
      rd_comb = '0;
      for (int j = 0; j < NRD; j++) begin
         rd_comb[j] = mem[raddr[j*N +: N]];
         for (int i = 0; i < NWR; i++)
            if (we_eff[i] && waddr[i*N +: N] == raddr[j*N +: N])
               rd_comb[j] = wdata[i*W +: W];
      end
   end

   if (RD_REG != 0) begin : g_rdreg
      logic [NRD-1:0][W-1:0] rd_q;

      always_ff @(posedge clk) begin
         if (!rst) begin
            rd_q <= '0;
         end else begin
            for (int j = 0; j < NRD; j++)
               rd_q[j] <= (clr_we && clr_addr == raddr[j*N +: N]) ? '0 : rd_comb[j];
         end
      end

      assign rd_out = rd_q;
   end else begin : g_rdcomb
      assign rd_out = rd_comb;
   end

   assign rdata = rd_out;

endmodule
